// File: rtl/ibex_irq_ctrl.sv
// ibex_irq_ctrl: interrupt sequencer between the raw interrupt lines and the
// core controller. Registers the lines, masks them, picks the highest-priority
// source and holds a stable request until it is acknowledged or withdrawn.
// NMI mode blocks a second NMI until the handler returns with MRET.
module ibex_irq_ctrl #(
  parameter int NumFastIrq = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_software_i,
  input  logic                  irq_timer_i,
  input  logic                  irq_external_i,
  input  logic [NumFastIrq-1:0] irq_fast_i,
  input  logic                  irq_nm_i,
  input  logic [17:0]           mie_i,
  input  logic                  mstatus_mie_i,
  input  logic                  debug_mode_i,
  input  logic                  irq_ack_i,
  input  logic                  mret_i,
  output logic                  irq_req_o,
  output logic [5:0]            irq_cause_o,
  output logic                  irq_pending_o,
  output logic                  irq_nm_mode_o,
  output logic [17:0]           mip_o
);

  localparam logic [5:0] CauseNm    = 6'h3F;
  localparam logic [5:0] CauseExt   = 6'h2B;
  localparam logic [5:0] CauseSw    = 6'h23;
  localparam logic [5:0] CauseTimer = 6'h27;

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  state_e      state_q, state_d;
  logic [17:0] mip_q;
  logic [14:0] fast_pad;
  logic [17:0] enabled;
  logic [5:0]  cause_q, cause_d;
  logic [5:0]  win_cause;
  logic        nmi_pend_q, nm_prev_q, nm_mode_q;
  logic        nmi_take, eligible, cause_en, withdraw;
  logic        nm_mode_set, nmi_clr;

  // Zero-pad the fast lines so the pending vector always has the 18-bit layout
  always_comb begin
    fast_pad = '0;
    fast_pad[NumFastIrq-1:0] = irq_fast_i;
  end

  assign enabled       = mip_q & mie_i;
  assign nmi_take      = nmi_pend_q & ~nm_mode_q;
  assign eligible      = ~debug_mode_i & (nmi_take | (mstatus_mie_i & (|enabled)));
  assign irq_pending_o = (|enabled) | nmi_pend_q;

  // Priority pick: walk from lowest to highest so the last hit wins
  always_comb begin
    win_cause = 6'h00;
    if (enabled[16]) win_cause = CauseTimer;
    if (enabled[17]) win_cause = CauseSw;
    if (enabled[15]) win_cause = CauseExt;
    for (int i = 14; i >= 0; i--) begin
      if (enabled[i]) win_cause = {1'b1, 5'(16 + i)};
    end
    if (nmi_take) win_cause = CauseNm;
  end

  // Is the source behind the latched cause still enabled?
  always_comb begin
    cause_en = 1'b0;
    if (cause_q == CauseExt)   cause_en = enabled[15];
    if (cause_q == CauseSw)    cause_en = enabled[17];
    if (cause_q == CauseTimer) cause_en = enabled[16];
    for (int i = 0; i < 15; i++) begin
      if (cause_q == {1'b1, 5'(16 + i)}) cause_en = enabled[i];
    end
  end

  assign withdraw = debug_mode_i |
                    ((cause_q != CauseNm) & (~mstatus_mie_i | ~cause_en));

  // Next-state logic: latch a cause on entry, leave on ack or withdraw
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    nm_mode_set = 1'b0;
    nmi_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = REQ;
          cause_d = win_cause;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = IDLE;
          if (cause_q == CauseNm) begin
            nm_mode_set = 1'b1;
            nmi_clr     = 1'b1;
          end
        end else if (withdraw) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Captured lines, latched cause, NMI edge detect and NMI mode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mip_q      <= '0;
      cause_q    <= 6'h00;
      nm_prev_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      nm_mode_q  <= 1'b0;
    end else begin
      mip_q     <= {irq_software_i, irq_timer_i, irq_external_i, fast_pad};
      cause_q   <= cause_d;
      nm_prev_q <= irq_nm_i;
      if (irq_nm_i & ~nm_prev_q) nmi_pend_q <= 1'b1;
      else if (nmi_clr)          nmi_pend_q <= 1'b0;
      if (nm_mode_set)               nm_mode_q <= 1'b1;
      else if (mret_i & nm_mode_q)   nm_mode_q <= 1'b0;
    end
  end

  assign irq_req_o     = (state_q == REQ);
  assign irq_cause_o   = cause_q;
  assign irq_nm_mode_o = nm_mode_q;
  assign mip_o         = mip_q;

`ifndef SYNTHESIS
  // An ack with no outstanding request points at a controller bug
  ack_only_in_req : assert property (@(posedge clk_i) disable iff (rst_i)
    irq_ack_i |-> (state_q == REQ));
`endif

endmodule
